// File: rtl/cache_line_ctrl.sv
// Direct-mapped cache line controller: probes the line array for CPU accesses,
// writes back dirty victims, refills a block one word per cycle and replays the access.
module cache_line_ctrl #(
    parameter int OFFSET_WIDTH = 3,
    parameter int INDEX_WIDTH  = 7,
    parameter int TAG_WIDTH    = 30 - OFFSET_WIDTH - INDEX_WIDTH,
    localparam int BLOCK_W     = 32 * (2 ** OFFSET_WIDTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cpu_req,
    input  logic                    cpu_we,
    input  logic [31:0]             cpu_addr,
    input  logic [3:0]              cpu_byte_en,
    input  logic [31:0]             cpu_wdata,
    output logic                    cpu_ready,
    output logic [31:0]             cpu_rdata,
    output logic                    line_enable,
    output logic                    line_cmp,
    output logic                    line_write,
    output logic [3:0]              line_byte_w_en,
    output logic                    line_valid_in,
    output logic [TAG_WIDTH-1:0]    line_tag,
    output logic [INDEX_WIDTH-1:0]  line_index,
    output logic [OFFSET_WIDTH-1:0] line_word_sel,
    output logic [31:0]             line_data_in,
    output logic [BLOCK_W-1:0]      line_block_in,
    input  logic                    line_hit,
    input  logic                    line_dirty,
    input  logic                    line_valid,
    input  logic [TAG_WIDTH-1:0]    line_tag_out,
    input  logic [31:0]             line_data_out,
    input  logic [BLOCK_W-1:0]      line_data_wb,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [31:0]             mem_addr,
    output logic [BLOCK_W-1:0]      mem_wdata,
    input  logic [BLOCK_W-1:0]      mem_rdata,
    input  logic                    mem_ack
);

    localparam int LOW_W   = OFFSET_WIDTH + 2;
    localparam int TAG_LSB = LOW_W + INDEX_WIDTH;
    localparam logic [OFFSET_WIDTH-1:0] CNT_LAST = {OFFSET_WIDTH{1'b1}};
    localparam logic [OFFSET_WIDTH-1:0] CNT_ONE  = {{(OFFSET_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOOKUP  = 3'd1,
        S_WB      = 3'd2,
        S_RD      = 3'd3,
        S_INSTALL = 3'd4,
        S_FILL    = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic [31:2]             addr_q, addr_d;
    logic                    we_q, we_d;
    logic [3:0]              be_q, be_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [OFFSET_WIDTH-1:0] count_q, count_d;
    logic [BLOCK_W-1:0]      fill_buf_q, fill_buf_d;
    logic                    cpu_ready_q, cpu_ready_d;
    logic [31:0]             cpu_rdata_q, cpu_rdata_d;
    logic                    mem_req_q, mem_req_d;
    logic                    mem_we_q, mem_we_d;
    logic [31:0]             mem_addr_q, mem_addr_d;
    logic [BLOCK_W-1:0]      mem_wdata_q, mem_wdata_d;

    logic [TAG_WIDTH-1:0]    tag_s;
    logic [INDEX_WIDTH-1:0]  index_s;
    logic [OFFSET_WIDTH-1:0] word_s;
    logic                    hit_s;
    logic                    unused_s;

    assign tag_s    = addr_q[31:TAG_LSB];
    assign index_s  = addr_q[TAG_LSB-1:LOW_W];
    assign word_s   = addr_q[LOW_W-1:2];
    assign hit_s    = line_hit & line_valid;
    assign unused_s = ^cpu_addr[1:0];

    assign cpu_ready = cpu_ready_q;
    assign cpu_rdata = cpu_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    // Next-state, latched request and registered output computation; array controls are per-state.
    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        we_d           = we_q;
        be_d           = be_q;
        wdata_d        = wdata_q;
        count_d        = count_q;
        fill_buf_d     = fill_buf_q;
        cpu_ready_d    = 1'b0;
        cpu_rdata_d    = 32'h0000_0000;
        mem_req_d      = mem_req_q;
        mem_we_d       = mem_we_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        line_enable    = 1'b0;
        line_cmp       = 1'b1;
        line_write     = 1'b0;
        line_byte_w_en = 4'hF;
        line_valid_in  = 1'b1;
        line_tag       = tag_s;
        line_index     = index_s;
        line_word_sel  = word_s;
        line_data_in   = wdata_q;
        line_block_in  = fill_buf_q;
        case (state_q)
            S_IDLE: begin
                // cpu_req is still high during the ready pulse; don't re-accept it
                if (cpu_req && !cpu_ready_q) begin
                    addr_d  = cpu_addr[31:2];
                    we_d    = cpu_we;
                    be_d    = cpu_byte_en;
                    wdata_d = cpu_wdata;
                    state_d = S_LOOKUP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOOKUP: begin
                line_enable    = 1'b1;
                line_cmp       = 1'b1;
                line_write     = we_q & hit_s;
                line_byte_w_en = be_q;
                if (hit_s) begin
                    cpu_ready_d = 1'b1;
                    cpu_rdata_d = we_q ? 32'h0000_0000 : line_data_out;
                    state_d     = S_IDLE;
                end else if (line_valid && line_dirty) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = {line_tag_out, index_s, {LOW_W{1'b0}}};
                    mem_wdata_d = line_data_wb;
                    state_d     = S_WB;
                end else begin
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = {tag_s, index_s, {LOW_W{1'b0}}};
                    state_d    = S_RD;
                end
            end
            S_WB: begin
                line_enable = 1'b1;
                line_cmp    = 1'b1;
                if (mem_ack) begin
                    mem_we_d   = 1'b0;
                    mem_addr_d = {tag_s, index_s, {LOW_W{1'b0}}};
                    state_d    = S_RD;
                end else begin
                    state_d = S_WB;
                end
            end
            S_RD: begin
                if (mem_ack) begin
                    fill_buf_d = mem_rdata;
                    mem_req_d  = 1'b0;
                    state_d    = S_INSTALL;
                end else begin
                    state_d = S_RD;
                end
            end
            S_INSTALL: begin
                line_enable = 1'b1;
                line_cmp    = 1'b0;
                line_write  = 1'b1;
                count_d     = {OFFSET_WIDTH{1'b0}};
                state_d     = S_FILL;
            end
            S_FILL: begin
                line_enable   = 1'b1;
                line_cmp      = 1'b0;
                line_write    = 1'b1;
                line_word_sel = count_q;
                if (count_q == CNT_LAST) begin
                    state_d = S_LOOKUP;
                end else begin
                    count_d = count_q + CNT_ONE;
                    state_d = S_FILL;
                end
            end
            default: begin
                mem_req_d = 1'b0;
                state_d   = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; async reset aborts any transfer immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            addr_q      <= 30'h0000_0000;
            we_q        <= 1'b0;
            be_q        <= 4'h0;
            wdata_q     <= 32'h0000_0000;
            count_q     <= {OFFSET_WIDTH{1'b0}};
            fill_buf_q  <= {BLOCK_W{1'b0}};
            cpu_ready_q <= 1'b0;
            cpu_rdata_q <= 32'h0000_0000;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0000_0000;
            mem_wdata_q <= {BLOCK_W{1'b0}};
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            count_q     <= count_d;
            fill_buf_q  <= fill_buf_d;
            cpu_ready_q <= cpu_ready_d;
            cpu_rdata_q <= cpu_rdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

endmodule

// File: tb/tb_cache_line_ctrl.sv
// Bench for cache_line_ctrl: behavioural line array and memory around the DUT, plus a
// word-level reference of CPU-visible data and line residency to predict traffic and load data.
module tb_cache_line_ctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cpu_req = 1'b0;
    logic         cpu_we = 1'b0;
    logic [31:0]  cpu_addr = 32'h0;
    logic [3:0]   cpu_byte_en = 4'h0;
    logic [31:0]  cpu_wdata = 32'h0;
    logic         cpu_ready;
    logic [31:0]  cpu_rdata;
    logic         line_enable, line_cmp, line_write, line_valid_in;
    logic [3:0]   line_byte_w_en;
    logic [19:0]  line_tag;
    logic [6:0]   line_index;
    logic [2:0]   line_word_sel;
    logic [31:0]  line_data_in;
    logic [255:0] line_block_in;
    logic         line_hit, line_dirty, line_valid;
    logic [19:0]  line_tag_out;
    logic [31:0]  line_data_out;
    logic [255:0] line_data_wb;
    logic         mem_req, mem_we;
    logic [31:0]  mem_addr;
    logic [255:0] mem_wdata;
    logic [255:0] mem_rdata = '0;
    logic         mem_ack = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    cache_line_ctrl dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_byte_en(cpu_byte_en), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
        .line_enable(line_enable), .line_cmp(line_cmp), .line_write(line_write),
        .line_byte_w_en(line_byte_w_en), .line_valid_in(line_valid_in),
        .line_tag(line_tag), .line_index(line_index), .line_word_sel(line_word_sel),
        .line_data_in(line_data_in), .line_block_in(line_block_in),
        .line_hit(line_hit), .line_dirty(line_dirty), .line_valid(line_valid),
        .line_tag_out(line_tag_out), .line_data_out(line_data_out), .line_data_wb(line_data_wb),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    // Line array environment: combinational read, valid bits cleared by reset.
    logic [19:0] a_tag   [128];
    logic        a_valid [128];
    logic        a_dirty [128];
    logic [31:0] a_data  [128][8];

    always_comb begin
        line_data_wb  = '0;
        line_hit      = line_enable && (a_tag[line_index] == line_tag);
        line_valid    = a_valid[line_index];
        line_dirty    = a_dirty[line_index];
        line_tag_out  = a_tag[line_index];
        line_data_out = a_data[line_index][line_word_sel];
        for (int w = 0; w < 8; w++) line_data_wb[255 - 32*w -: 32] = a_data[line_index][w];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 128; i++) begin
                a_valid[i] <= 1'b0;
                a_dirty[i] <= 1'b0;
                a_tag[i]   <= 20'h0;
            end
        end else if (line_enable && line_write) begin
            if (line_cmp) begin
                if (a_valid[line_index] && a_tag[line_index] == line_tag) begin
                    for (int b = 0; b < 4; b++)
                        if (line_byte_w_en[b])
                            a_data[line_index][line_word_sel][8*b +: 8] <= line_data_in[8*b +: 8];
                    a_dirty[line_index] <= 1'b1;
                end
            end else begin
                if (a_valid[line_index] && a_tag[line_index] == line_tag)
                    a_data[line_index][line_word_sel] <= line_block_in[32*int'(line_word_sel) +: 32];
                a_tag[line_index]   <= line_tag;
                a_valid[line_index] <= line_valid_in;
                a_dirty[line_index] <= 1'b0;
            end
        end
    end

    // Memory words, and the CPU-visible reference view (stores not yet written back).
    logic [31:0] mem_words [int unsigned];
    logic [31:0] ref_words [int unsigned];
    logic [19:0] res_tag   [128];
    bit          res_valid [128];
    bit          res_dirty [128];

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        int unsigned k;
        k = {2'b00, a[31:2]};
        if (mem_words.exists(k)) return mem_words[k];
        return ({a[31:2], 2'b00} * 32'h9E37_79B1) + 32'h1234_5678;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        int unsigned k;
        k = {2'b00, a[31:2]};
        if (ref_words.exists(k)) return ref_words[k];
        return mem_read(a);
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_cpu_ready"},   256'(cpu_ready),   256'(0));
        check({tag, "_cpu_rdata"},   256'(cpu_rdata),   256'(0));
        check({tag, "_mem_req"},     256'(mem_req),     256'(0));
        check({tag, "_line_enable"}, 256'(line_enable), 256'(0));
        check({tag, "_line_write"},  256'(line_write),  256'(0));
    endtask

    task automatic forget_cache();
        for (int i = 0; i < 128; i++) begin
            res_valid[i] = 1'b0;
            res_dirty[i] = 1'b0;
        end
        ref_words.delete();
    endtask

    // One CPU access with the memory responder; abort_fill>=0 pulls reset at that fill count.
    task automatic do_access(input logic we, input logic [31:0] addr, input logic [3:0] be,
                             input logic [31:0] wd, input int delay, input int abort_fill);
        logic [6:0]   idx;
        logic [19:0]  tg;
        bit           hit, wb, in_tx, rd_bad, stab_bad, aborted;
        logic [31:0]  wb_addr, exp_rd, rd_obs, cur_addr, old;
        logic [255:0] wb_blk, cur_wd;
        logic         cur_we;
        int           n_ready, ready_cyc, fills, waitc;
        logic [31:0]  tq_addr[$];
        logic         tq_we[$];
        logic [255:0] tq_wd[$];
        idx = addr[11:5];
        tg  = addr[31:12];
        hit = res_valid[idx] && res_tag[idx] == tg;
        wb  = !hit && res_valid[idx] && res_dirty[idx];
        wb_addr = {res_tag[idx], idx, 5'b0};
        wb_blk  = '0;
        for (int w = 0; w < 8; w++) wb_blk[255 - 32*w -: 32] = ref_read(wb_addr + 32'(4*w));
        exp_rd = ref_read(addr);
        in_tx = 0; rd_bad = 0; stab_bad = 0; aborted = 0;
        n_ready = 0; ready_cyc = 0; fills = 0; waitc = 0; rd_obs = 32'h0;
        cur_addr = 32'h0; cur_we = 1'b0; cur_wd = '0;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_byte_en = be; cpu_wdata = wd;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            mem_ack = 1'b0;
            mem_rdata = '0;
            if (in_tx && !mem_req) stab_bad = 1;
            if (mem_req) begin
                if (!in_tx) begin
                    in_tx = 1; cur_addr = mem_addr; cur_we = mem_we; cur_wd = mem_wdata; waitc = 0;
                end else if (mem_addr !== cur_addr || mem_we !== cur_we || (cur_we && mem_wdata !== cur_wd)) begin
                    stab_bad = 1;
                end
                waitc++;
                if (waitc > delay) begin
                    mem_ack = 1'b1;
                    tq_addr.push_back(cur_addr); tq_we.push_back(cur_we); tq_wd.push_back(cur_wd);
                    if (cur_we) begin
                        for (int w = 0; w < 8; w++)
                            mem_words[{2'b00, cur_addr[31:2]} + 32'(w)] = cur_wd[255 - 32*w -: 32];
                    end else begin
                        for (int w = 0; w < 8; w++) mem_rdata[32*w +: 32] = mem_read(cur_addr + 32'(4*w));
                    end
                    in_tx = 0;
                end
            end
            if (line_enable && !line_cmp && line_write) begin
                fills++;
                if (abort_fill >= 0 && fills == abort_fill + 2) begin
                    rst = 1'b0;
                    #1;
                    check_outputs_zero("abort");
                    aborted = 1;
                    break;
                end
            end
            if (cpu_ready) begin
                n_ready++;
                if (n_ready == 1) begin ready_cyc = cyc; rd_obs = cpu_rdata; end
                cpu_req = 1'b0;
            end else if (cpu_rdata !== 32'h0) begin
                rd_bad = 1;
            end
            if (cpu_req && cyc >= 1) begin
                cpu_addr = $urandom; cpu_wdata = $urandom; cpu_byte_en = 4'($urandom); cpu_we = 1'($urandom);
            end
            if (n_ready > 0 && cyc >= ready_cyc + 3) break;
        end
        if (aborted) begin
            cpu_req = 1'b0; mem_ack = 1'b0;
            check("abort_no_ready", 256'(n_ready), 256'(0));
            repeat (2) @(negedge clk);
            rst = 1'b1;
            forget_cache();
        end else begin
            check("ready_count", 256'(n_ready), 256'(1));
            if (!we) check("load_data", 256'(rd_obs), 256'(exp_rd));
            check("rdata_zero_otherwise", 256'(rd_bad), 256'(0));
            if (hit) check("hit_latency", 256'(ready_cyc), 256'(2));
            check("mem_txn_count", 256'(tq_addr.size()), 256'(hit ? 0 : (wb ? 2 : 1)));
            check("fill_cycles", 256'(fills), 256'(hit ? 0 : 9));
            check("mem_held_until_ack", 256'(stab_bad), 256'(0));
            if (wb && tq_addr.size() >= 1) begin
                check("wb_addr", 256'(tq_addr[0]), 256'(wb_addr));
                check("wb_we", 256'(tq_we[0]), 256'(1));
                check("wb_data", tq_wd[0], wb_blk);
            end
            if (!hit && tq_addr.size() == (wb ? 2 : 1)) begin
                check("rd_addr", 256'(tq_addr[tq_addr.size()-1]), 256'({tg, idx, 5'b0}));
                check("rd_we", 256'(tq_we[tq_we.size()-1]), 256'(0));
            end
            if (we) begin
                old = ref_read(addr);
                for (int b = 0; b < 4; b++) if (be[b]) old[8*b +: 8] = wd[8*b +: 8];
                ref_words[{2'b00, addr[31:2]}] = old;
            end
            res_dirty[idx] = hit ? (res_dirty[idx] | we) : we;
            res_valid[idx] = 1'b1;
            res_tag[idx]   = tg;
        end
    endtask

    initial begin
        logic [31:0] a, d, merged;
        logic [19:0] tg;
        logic [6:0]  idx;
        logic [2:0]  w;
        forget_cache();
        #2 rst = 1'b0;
        #1;
        check_outputs_zero("reset");
        repeat (2) @(negedge clk);
        check_outputs_zero("reset_held");
        rst = 1'b1;
        @(negedge clk);

        // Cold load, then a hit in the same block.
        do_access(1'b0, 32'h0000_1004, 4'hF, 32'h0, 0, -1);
        do_access(1'b0, 32'h0000_1008, 4'hF, 32'h0, 0, -1);

        // Partial store on a hit, then read back the merged word.
        merged = {mem_read(32'h0000_1004) >> 16, 16'hBEEF};
        do_access(1'b1, 32'h0000_1004, 4'b0011, 32'hDEAD_BEEF, 0, -1);
        check("store_merge_ref", 256'(ref_read(32'h0000_1004)), 256'(merged));
        do_access(1'b0, 32'h0000_1004, 4'hF, 32'h0, 0, -1);

        // Conflicting tag forces write-back of the dirty block; slow memory.
        do_access(1'b0, 32'h0000_3004, 4'hF, 32'h0, 10, -1);
        check("wb_landed_in_memory", 256'(mem_read(32'h0000_1004)), 256'(merged));

        // Reset during fill count 4, then the same load misses and completes.
        do_access(1'b0, 32'h0000_5004, 4'hF, 32'h0, 0, 4);
        @(negedge clk);
        check_outputs_zero("after_abort");
        do_access(1'b0, 32'h0000_5004, 4'hF, 32'h0, 0, -1);

        // Randomised traffic over a few conflicting sets; stray acks while idle.
        for (int i = 0; i < 40; i++) begin
            if (($urandom % 5) == 0) begin
                mem_ack = 1'b1; mem_rdata = {8{32'hBAD0_BAD0}};
                @(negedge clk);
                mem_ack = 1'b0; mem_rdata = '0;
                check("stray_ack_ignored", 256'(mem_req), 256'(0));
            end
            tg  = 20'($urandom_range(0, 3) * 2 + 1);
            idx = 7'($urandom_range(0, 2));
            w   = 3'($urandom_range(0, 7));
            a   = {tg, idx, w, 2'b00};
            d   = $urandom;
            do_access(1'($urandom_range(0, 1)), a, 4'($urandom_range(1, 15)), d, $urandom_range(0, 3), -1);
        end

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
